// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit types and constants: bus width, NOP encoding, queue entry layout.
// Pure declarations; no timing or flow-control behaviour.
package ifu_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } fetch_ent_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// 2-entry synchronous FIFO with flush, same-cycle push/pop and occupancy count.
// Head visible combinationally; push into a full FIFO is accepted only alongside a pop.
module ifu_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC generation, pipelined bus reads, 2-entry {addr,data} queue to IF/ID; optional IFU_MISALIGN_CHK_EN.
// Bus data reaches inst_o the cycle after rvalid; requests stall when outstanding + queued words would exceed 2.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_flag_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            ibus_req_o,
  output logic [XLEN-1:0] ibus_addr_o,
  input  logic            ibus_gnt_i,
  input  logic            ibus_rvalid_i,
  input  logic [XLEN-1:0] ibus_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] inst_o
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
`endif
);

  logic [XLEN-1:0] pc;
  logic [1:0]      disc_cnt;
  logic [1:0]      out_cnt;
  logic [1:0]      inst_cnt;
  logic [XLEN-1:0] rsp_addr;
  fetch_ent_t      head;
  fetch_ent_t      push_ent;
  logic            halted;
  logic            consume;
  logic            rsp_ok;
  logic            keep;
  logic            credit;
  logic            fire;
  logic [2:0]      occupancy;

  assign inst_valid_o = (inst_cnt != 2'd0);
  assign consume      = inst_valid_o && !hold_flag_i && !jump_en_i;
  assign rsp_ok       = ibus_rvalid_i && (out_cnt != 2'd0);
  assign keep         = rsp_ok && (disc_cnt == 2'd0) && !jump_en_i;

  // The head slot freed by this cycle's consumption already counts as free,
  // which lets a 1-cycle bus stream one word per cycle.
  assign occupancy  = {1'b0, out_cnt} + {1'b0, inst_cnt} - {2'b00, consume};
  assign credit     = rst && !jump_en_i && !halted && (occupancy < 3'd2);
  assign fire       = credit && ibus_gnt_i;
  assign ibus_req_o = credit;
  assign ibus_addr_o = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (jump_en_i) begin
      pc <= word_align(jump_addr_i);
    end else if (fire) begin
      pc <= pc + 32'd4;
    end
  end

  // Responses already in flight at a jump belong to the old stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disc_cnt <= 2'd0;
    end else if (jump_en_i) begin
      disc_cnt <= out_cnt - {1'b0, rsp_ok};
    end else if (rsp_ok && (disc_cnt != 2'd0)) begin
      disc_cnt <= disc_cnt - 2'd1;
    end
  end

  ifu_fifo #(.WIDTH(XLEN)) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (fire),
    .pop   (rsp_ok),
    .wdata (pc),
    .rdata (rsp_addr),
    .count (out_cnt)
  );

  assign push_ent.addr = rsp_addr;
  assign push_ent.data = ibus_rdata_i;

  ifu_fifo #(.WIDTH($bits(fetch_ent_t))) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_en_i),
    .push  (keep),
    .pop   (consume),
    .wdata (push_ent),
    .rdata (head),
    .count (inst_cnt)
  );

  assign inst_o      = inst_valid_o ? head.data : INST_NOP;
  assign inst_addr_o = inst_valid_o ? head.addr : '0;

`ifdef IFU_MISALIGN_CHK_EN
  logic mis_jump;
  assign mis_jump = jump_en_i && (jump_addr_i[1:0] != 2'b00);

  // A misaligned target parks the fetcher until the next redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted          <= 1'b0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= mis_jump;
      if (jump_en_i) halted <= mis_jump;
      if (mis_jump) misalign_addr_o <= jump_addr_i;
    end
  end
`else
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr_i[1:0];
  assign halted          = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch: behavioural bus responder plus a queue-level model of the fetch stream.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_flag_i, jump_en_i, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] jump_addr_i, ibus_rdata_i;
  logic        ibus_req_o, inst_valid_o;
  logic [31:0] ibus_addr_o, inst_addr_o, inst_o;
`ifdef IFU_MISALIGN_CHK_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .hold_flag_i   (hold_flag_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_addr_o   (inst_addr_o),
    .inst_o        (inst_o)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  int          cyc, last_due, lat_min, lat_max;
  int          n_checks, n_errors;
  bit          spur_en;
  int          m_out, m_q, m_disc;
  logic [31:0] m_pc, m_exp, m_mis_addr;
  bit          m_halt, m_mis;
  logic        s_valid, s_req, s_mis;
  logic [31:0] s_inst, s_iaddr, s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_q = 0; m_disc = 0;
    m_pc = RPC; m_exp = RPC;
    m_halt = 0; m_mis = 0; m_mis_addr = '0;
    rq.delete();
    last_due = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    hold_flag_i = 0; jump_en_i = 0; jump_addr_i = 0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 0;
    model_reset();
    #1;
    chk("rst_req", ibus_req_o, 0);
    chk("rst_addr", ibus_addr_o, RPC);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, INST_NOP);
    chk("rst_iaddr", inst_addr_o, 0);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst_mis", misalign_o, 0);
`endif
    repeat (n) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_req", ibus_req_o, 1);
    chk("first_addr", ibus_addr_o, RPC);
  endtask

  // One bus cycle: drive at negedge, check 1ns later, advance the model at posedge.
  task automatic step(input logic h, input logic j, input logic [31:0] ja, input logic g);
    logic rv, rv_q, rv_ok, consume, credit, fire;
    rsp_t e;
    @(negedge clk);
    rv = 0; rv_q = 0;
    ibus_rdata_i = 32'h0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rv = 1; rv_q = 1;
      ibus_rdata_i = mem_word(rq[0].addr);
    end else if (spur_en && rq.size() == 0 && m_out == 0 && $urandom_range(0, 9) == 0) begin
      rv = 1;
      ibus_rdata_i = 32'hdead_beef;
    end
    hold_flag_i = h; jump_en_i = j; jump_addr_i = ja; ibus_gnt_i = g; ibus_rvalid_i = rv;
    #1;
    consume = (m_q > 0) && !h && !j;
    credit  = (m_out + m_q - int'(consume) < 2) && !j && !m_halt;
    fire    = credit && g;
    rv_ok   = rv && (m_out > 0);
    s_valid = inst_valid_o; s_inst = inst_o; s_iaddr = inst_addr_o;
    s_addr = ibus_addr_o; s_req = ibus_req_o;
    chk("ibus_req", ibus_req_o, credit);
    chk("ibus_addr", ibus_addr_o, m_pc);
    chk("inst_valid", inst_valid_o, m_q > 0);
    if (m_q == 0) chk("idle_nop", inst_o, INST_NOP);
    if (consume) begin
      chk("inst_addr", inst_addr_o, m_exp);
      chk("inst_data", inst_o, mem_word(m_exp));
    end
`ifdef IFU_MISALIGN_CHK_EN
    s_mis = misalign_o;
    chk("misalign", misalign_o, m_mis);
    if (m_mis) chk("misalign_addr", misalign_addr_o, m_mis_addr);
`else
    s_mis = 0;
`endif
    @(posedge clk);
    if (rv_q) void'(rq.pop_front());
    if (fire) begin
      e.addr = m_pc;
      e.due = cyc + $urandom_range(lat_min, lat_max);
      if (e.due <= last_due) e.due = last_due + 1;
      last_due = e.due;
      rq.push_back(e);
    end
    if (j) begin
      m_disc = m_out - int'(rv_ok);
      m_out  = m_out - int'(rv_ok);
      m_q    = 0;
      m_pc   = {ja[31:2], 2'b00};
      m_exp  = {ja[31:2], 2'b00};
`ifdef IFU_MISALIGN_CHK_EN
      m_mis = (ja[1:0] != 2'b00);
      m_halt = m_mis;
      m_mis_addr = ja;
`endif
    end else begin
      m_out = m_out + int'(fire) - int'(rv_ok);
      if (rv_ok) begin
        if (m_disc > 0) m_disc--;
        else m_q++;
      end
      if (consume) begin
        m_q--;
        m_exp += 32'd4;
      end
      if (fire) m_pc += 32'd4;
      m_mis = 0;
    end
    cyc++;
  endtask

  task automatic wait_target(input string tag, input logic [31:0] target);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(0, 0, 0, 1);
      if (s_valid) begin
        seen = 1;
        chk(tag, s_iaddr, target);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, frozen;
    logic [31:0] ja;
    bit hit;
    n_checks = 0; n_errors = 0; cyc = 0;
    spur_en = 0; lat_min = 1; lat_max = 1;
    rst = 1'b0;
    do_reset(3);

    // Streaming with single-cycle memory.
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1);
      if (i >= 2) chk("stream_vld", s_valid, 1);
    end

    // Three-cycle hold mid-stream.
    step(1, 0, 0, 1);
    frozen = s_inst;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1);
      chk("hold_frozen", s_inst, frozen);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Jump with two requests in flight.
    lat_min = 3; lat_max = 3;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_out == 2) hit = 1;
      else step(0, 0, 0, 1);
    end
    chk("setup_out2", hit, 1);
    step(0, 1, 32'h100, 1);
    step(0, 0, 0, 1);
    chk("jump_novalid", s_valid, 0);
    wait_target("jump_target", 32'h100);

    // Jump coinciding with a response and a hold.
    lat_min = 2; lat_max = 2;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (rq.size() > 0 && rq[0].due <= cyc && m_q > 0) begin
        step(1, 1, 32'h300, 1);
        hit = 1;
      end else begin
        step(0, 0, 0, 1);
      end
    end
    chk("jmp_rv_hit", hit, 1);
    wait_target("jmp_rv_target", 32'h300);

    // Grant withheld four cycles per request, read latency three.
    lat_min = 3; lat_max = 3;
    for (int r = 0; r < 6; r++) begin
      step(0, 0, 0, 0);
      a0 = s_addr;
      for (int k = 0; k < 3; k++) begin
        step(0, 0, 0, 0);
        chk("gnt_wait_addr", s_addr, a0);
      end
      step(0, 0, 0, 1);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

`ifdef IFU_MISALIGN_CHK_EN
    step(0, 1, 32'h102, 1);
    step(0, 0, 0, 1);
    chk("mis_pulse", s_mis, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      chk("mis_noreq", s_req, 0);
    end
    step(0, 1, 32'h200, 1);
    wait_target("mis_resume", 32'h200);
`endif

    // Random traffic with redirects, wrap-around targets, stray responses and resets.
    spur_en = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
      end else begin
        ja = ($urandom_range(0, 7) == 0) ? 32'hffff_fff0 : $urandom;
        if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
        step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, ja,
             $urandom_range(0, 9) < 7);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
